// File: rtl/int_issue_ctl.sv
// rtl/int_issue_ctl.sv - issue/hazard control and register-file write-port arbitration for the 3-stage integer pipeline
module int_issue_ctl #(
  parameter int         LD_MAX    = 4,
  parameter logic [3:0] NOP_OP    = 4'h0,
  parameter int         DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic [12:0] inst,
  output logic        inst_ready,
  output logic [3:0]  opcode,
  output logic [2:0]  a,
  output logic [2:0]  b,
  output logic [2:0]  c,
  output logic        empty,
  output logic        pause,
  input  logic        pipe_cwrite,
  input  logic [2:0]  pipe_csel,
  input  logic [15:0] pipe_cout,
  input  logic        ld_req,
  input  logic [2:0]  ld_sel,
  input  logic [15:0] ld_dat,
  output logic        ld_gnt,
  output logic        rf_we,
  output logic [2:0]  rf_sel,
  output logic [15:0] rf_dat
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, LDSTALL = 2'd3} state_t;

  state_t          state, state_nxt, norm_nxt, ret_state, ret_nxt;
  // Stage 2 is covered by forwarding, so only the output slot and stage 1 are tracked.
  logic [1:0]      dst_v;
  logic [1:0][2:0] dst_r;
  logic [3:0]      wait_cnt;
  logic [2:0]      drain_cnt;
  logic [2:0]      src_a, src_b;
  logic            hazard, accept, ld_deny, go_stall, last_drain;
  logic            adv, load_drain, dec_drain, set_empty, clr_empty;

  assign src_a = inst[8:6];
  assign src_b = inst[5:3];

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (dst_v[i] && (src_a == dst_r[i] || src_b == dst_r[i])) hazard = 1'b1;
    end
  end

  assign inst_ready = rst_n && (state != LDSTALL) && !hazard;
  assign accept     = inst_valid && inst_ready;

  assign ld_gnt   = ld_req && (!pipe_cwrite || state == LDSTALL);
  assign ld_deny  = ld_req && !ld_gnt;
  assign go_stall = ld_deny && (wait_cnt == 4'(LD_MAX - 1));
  assign rf_we    = pipe_cwrite || ld_gnt;
  assign rf_sel   = ld_gnt ? ld_sel : pipe_csel;
  assign rf_dat   = ld_gnt ? ld_dat : pipe_cout;

  assign last_drain = (state == DRAIN) && !accept && (drain_cnt == 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ret_state <= IDLE;
    end else begin
      state <= state_nxt;
      if (go_stall) ret_state <= ret_nxt;
    end
  end

  always_comb begin
    norm_nxt = state;
    case (state)
      IDLE:    if (accept) norm_nxt = RUN;
      RUN:     if (!inst_valid) norm_nxt = DRAIN;
      DRAIN: begin
        if (accept) norm_nxt = RUN;
        else if (drain_cnt == 3'd1) norm_nxt = IDLE;
      end
      LDSTALL: norm_nxt = ret_state;
      default: norm_nxt = IDLE;
    endcase
    // A stall that collides with the final drain step defers the idle entry until after the stall.
    ret_nxt   = last_drain ? DRAIN : norm_nxt;
    state_nxt = go_stall ? LDSTALL : norm_nxt;
  end

  always_comb begin
    adv        = (state != LDSTALL);
    load_drain = (state == RUN) && !inst_valid;
    dec_drain  = (state == DRAIN) && !accept && !(last_drain && go_stall);
    set_empty  = last_drain && !go_stall;
    clr_empty  = (state == IDLE) && accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause     <= 1'b0;
      empty     <= 1'b1;
      drain_cnt <= 3'd0;
      wait_cnt  <= 4'd0;
      dst_v     <= 2'b00;
      dst_r     <= '0;
      opcode    <= NOP_OP;
      a         <= 3'd0;
      b         <= 3'd0;
      c         <= 3'd0;
    end else begin
      pause <= (state_nxt == LDSTALL);
      if (set_empty) empty <= 1'b1;
      else if (clr_empty) empty <= 1'b0;
      if (load_drain) drain_cnt <= 3'(DRAIN_CYC);
      else if (dec_drain) drain_cnt <= drain_cnt - 3'd1;
      if (!ld_req || ld_gnt) wait_cnt <= 4'd0;
      else wait_cnt <= wait_cnt + 4'd1;
      if (adv) begin
        dst_v  <= {dst_v[0], accept};
        dst_r  <= {dst_r[0], accept ? inst[2:0] : 3'd0};
        opcode <= accept ? inst[12:9] : NOP_OP;
        a      <= accept ? inst[8:6] : 3'd0;
        b      <= accept ? inst[5:3] : 3'd0;
        c      <= accept ? inst[2:0] : 3'd0;
      end
    end
  end

endmodule

// File: doc/int_issue_ctl.md
# int_issue_ctl

Issue and write-port controller for the 3-stage integer pipeline. It accepts decoded instructions from fetch over a valid/ready handshake and presents them to the pipeline. It inserts NOP bubbles on read-after-write hazards that forwarding does not cover, and drives the pipeline's EMPTY and PAUSE inputs. It also arbitrates the single register-file write port between pipeline write-back and the load unit.

## Interface
- LD_MAX, 4: cycles a load request may wait before the pipeline is paused to grant it (1..15).
- NOP_OP, 4'h0: opcode issued as a bubble; the ALU produces no write-back for it.
- DRAIN_CYC, 3: bubbles issued after the last instruction before EMPTY is raised.
- CLK in 1: clock, all state on rising edge.
- RST_N in 1: asynchronous, active-low reset.
- INST_VALID in 1: fetch has an instruction on INST.
- INST in 13: {opcode[12:9], A[8:6], B[5:3], C[2:0]}.
- INST_READY out 1: instruction accepted this cycle when INST_VALID is also high.
- OPCODE out 4, A out 3, B out 3, C out 3: instruction presented to the pipeline (registered).
- EMPTY out 1: pipeline flush/idle (registered).
- PAUSE out 1: pipeline hold (registered).
- PIPE_CWRITE in 1: pipeline write-back strobe (already masked by PAUSE).
- PIPE_CSEL in 3: pipeline write-back register.
- PIPE_COUT in 16: pipeline write-back data.
- LD_REQ in 1: load unit write request, held until granted.
- LD_SEL in 3: load destination register.
- LD_DAT in 16: load data.
- LD_GNT out 1: load write performed this cycle (combinational).
- RF_WE out 1: register-file write enable (combinational).
- RF_SEL out 3: register-file write address (combinational).
- RF_DAT out 16: register-file write data (combinational).

## Operation
- **Reset values** (RST_N low):
  - State IDLE; EMPTY=1, PAUSE=0.
  - OPCODE=NOP_OP, A=B=C=0.
  - All in-flight entries invalid; wait counter 0.
  - INST_READY=0 (gated by RST_N).
- **In-flight tracking:**
  - Three entries dst[0..2], each {valid, reg}. dst[0] is the instruction on the outputs; dst[1] and dst[2] are pipeline stages 1 and 2.
  - The entries shift on every edge where PAUSE=0. The issued instruction enters dst[0], valid=1. A bubble enters dst[0] with valid=0.
- **Hazard:** new INST A or B equals the reg of a valid dst[0] or valid dst[1]. dst[2] is covered by pipeline forwarding.
- **INST_READY:** 1 when RST_N=1, state is not LDSTALL, and there is no hazard.
- **States:**
  - IDLE: EMPTY=1.
    - INST_VALID & INST_READY: issue the instruction, EMPTY←0, go to RUN.
  - RUN: every cycle issues either the accepted instruction or a NOP bubble (hazard).
    - INST_VALID=0: load counter with DRAIN_CYC, go to DRAIN, issue a bubble.
  - DRAIN: issue bubbles and decrement the counter.
    - INST_VALID & INST_READY: issue the instruction, go to RUN.
    - Counter reaches 0 with no valid instruction: EMPTY←1, go to IDLE.
  - LDSTALL: lasts exactly one cycle. PAUSE=1, outputs and dst entries frozen, INST_READY=0. Returns to the state it came from.
- **Write arbitration:**
  - LD_GNT = LD_REQ & (~PIPE_CWRITE | state==LDSTALL).
  - RF_WE = PIPE_CWRITE | LD_GNT.
  - RF_SEL and RF_DAT come from the load unit when LD_GNT=1, otherwise from the pipeline.
- **Starvation guard:**
  - The wait counter increments each cycle with LD_REQ & ~LD_GNT, and clears on LD_GNT or when LD_REQ=0.
  - When the counter equals LD_MAX-1 and the request is denied again, the next state is LDSTALL. PAUSE is registered, so it asserts on the following cycle.
- **Simultaneous events:**
  - LDSTALL entry takes precedence over drain-to-IDLE.
  - In IDLE, LD_GNT follows the formula above; PIPE_CWRITE is 0 while EMPTY=1.
- **Ordering:** write-after-write conflicts between the load unit and in-flight instructions are excluded by software ordering and are not checked.
- **Async reset mid-operation:** all state returns to reset values immediately. A load request pending at reset must be re-presented.

## Timing
- Issue latency: an instruction accepted at edge N appears on OPCODE/A/B/C after edge N and is sampled by the pipeline at edge N+1.
- Write-back strobe: appears 3 pipeline-advancing cycles after issue.
- Bubble cost: one hazard costs 1 or 2 bubbles, depending on whether the conflict is with dst[0] or dst[1].
- Pause length: PAUSE is high for exactly one cycle per LDSTALL.
- Load grant: combinational, in the same cycle as the free slot.
- Idle entry: EMPTY rises DRAIN_CYC+1 edges after the last accept.

## Test plan
- **Reset:** hold RST_N=0 with INST_VALID=1 → EMPTY=1, PAUSE=0, INST_READY=0, OPCODE=NOP_OP. Release → INST_READY=1.
- **Back-to-back independent issue:** r1←r2+r3 then r4←r5+r6 → both accepted on consecutive edges, no bubbles, EMPTY falls after the first edge.
- **Dependent issue:** r1←r2+r3, then r5←r1+r4 → INST_READY=0 for 2 cycles and two NOP_OP issued. The second instruction is accepted on the third cycle; with an intervening independent op, only 1 bubble.
- **Drain:** issue one instruction, then INST_VALID=0 → 3 bubbles, EMPTY=1 on the 4th edge. A valid instruction arriving during DRAIN returns to RUN with no EMPTY pulse.
- **Load arbitration, free slot:** LD_REQ with LD_SEL=7, LD_DAT=16'hBEEF while PIPE_CWRITE=0 → same-cycle LD_GNT=1, RF_WE=1, RF_SEL=7, RF_DAT=16'hBEEF.
- **Load starvation:** LD_REQ held while PIPE_CWRITE=1 every cycle, LD_MAX=4 → denied 4 cycles, PAUSE=1 for exactly one cycle with LD_GNT=1, outputs frozen, pipeline resumes the next cycle. Assert RST_N=0 during LDSTALL → PAUSE=0 immediately.
